// File: rtl/config_jtag_tx.sv
// config_jtag_tx: serial transmitter for the JTAG-style config link.
// Optional keepalive resend enabled by defining CFG_JTAG_TX_KEEPALIVE_EN.
module config_jtag_tx #(
   parameter int          DATA_W        = 32,
   parameter int          PAT_W         = 16,
   parameter logic [15:0] SYNC_WORD     = 16'hFAB1,
   parameter logic [15:0] RST_WORD      = 16'hFAB0,
   parameter int          KEEPALIVE_GAP = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_valid,
   input  logic              rst_req,
   output logic              cfg_ready,
   output logic              tms,
   output logic              sdata,
   output logic              busy,
   output logic              frame_done
);

   localparam int IW = $clog2(DATA_W);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [DATA_W-1:0]   word_sr;
   logic [PAT_W-1:0]    pat_sr;
   logic                last_bit;
   logic                accept;
   logic                load;
   logic                ka_fire;
   logic [DATA_W-1:0]   load_word;
   logic [PAT_W-1:0]    load_pat;

   assign last_bit = (state == SEND) && (idx == IW'(DATA_W - 1));

`ifdef CFG_JTAG_TX_KEEPALIVE_EN
   localparam int CW = $clog2(KEEPALIVE_GAP + 1);

   logic [CW-1:0]     ka_cnt;
   logic [DATA_W-1:0] last_word;

   assign ka_fire = (state == IDLE) && (ka_cnt == CW'(KEEPALIVE_GAP - 1));

   // Idle-cycle counter and the last data word, for the keepalive resend
   always_ff @(posedge clk) begin
      if (reset) begin
         ka_cnt    <= '0;
         last_word <= '0;
      end else begin
         if (accept && !rst_req)
            last_word <= cfg_data;
         if (load)
            ka_cnt <= '0;
         else if (state == IDLE)
            ka_cnt <= ka_cnt + 1'b1;
         else
            ka_cnt <= '0;
      end
   end

   assign load_word = ka_fire ? last_word :
                      rst_req ? '0 : cfg_data;
`else
   assign ka_fire   = 1'b0;
   assign load_word = rst_req ? '0 : cfg_data;
`endif

   assign cfg_ready = !reset && !ka_fire && ((state == IDLE) || last_bit);
   assign accept    = cfg_ready && (rst_req || cfg_valid);
   assign load      = accept || ka_fire;
   assign load_pat  = (accept && rst_req) ? RST_WORD : SYNC_WORD;
   assign busy      = (state == SEND);

   // Frame FSM: loads a frame on accept and shifts one bit per cycle, MSB first
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         word_sr    <= '0;
         pat_sr     <= '0;
         tms        <= 1'b0;
         sdata      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_bit;
         if (load) begin
            state   <= SEND;
            idx     <= '0;
            sdata   <= load_word[DATA_W-1];
            word_sr <= load_word << 1;
            pat_sr  <= load_pat;
            tms     <= 1'b0;
         end else if (state == SEND && !last_bit) begin
            idx     <= idx + 1'b1;
            sdata   <= word_sr[DATA_W-1];
            word_sr <= word_sr << 1;
            // pattern bits occupy the last PAT_W cycles of the frame
            if (idx >= IW'(DATA_W - PAT_W - 1)) begin
               tms    <= pat_sr[PAT_W-1];
               pat_sr <= pat_sr << 1;
            end else begin
               tms <= 1'b0;
            end
         end else begin
            state <= IDLE;
            idx   <= '0;
            tms   <= 1'b0;
            sdata <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_config_jtag_tx.sv
// tb_config_jtag_tx: directed plus random stimulus against a frame-level
// reference model and a receiver model watching the tms/sdata stream.
module tb_config_jtag_tx;

   localparam logic [15:0] SYNC = 16'hFAB1;
   localparam logic [15:0] RSTW = 16'hFAB0;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cfg_data;
   logic        cfg_valid;
   logic        rst_req;
   logic        cfg_ready;
   logic        tms;
   logic        sdata;
   logic        busy;
   logic        frame_done;

   config_jtag_tx dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_data   (cfg_data),
      .cfg_valid  (cfg_valid),
      .rst_req    (rst_req),
      .cfg_ready  (cfg_ready),
      .tms        (tms),
      .sdata      (sdata),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // model: p = frame bit position (-1 idle), word and pattern of frame
   int          p = -1;
   logic [31:0] mword = '0;
   logic [15:0] mpat = '0;
   bit          mfd = 1'b0;
   bit          acc = 1'b0;
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
   int          ic = 0;
   logic [31:0] mlast = '0;
`endif

   // receiver model
   logic [31:0] rdata = '0;
   logic [15:0] rtms = '0;
   logic [31:0] rx_word = '0;
   int          nsync = 0;
   int          nrst = 0;
   int          since_rst = 0;
   int          cyc = 0;
   int          sync_cyc = 0;
   int          prev_sync_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle(input bit r, input bit v, input bit q,
                        input logic [31:0] d);
      bit fire;
      bit mready;
      bit exp_s;
      bit exp_t;
      reset     = r;
      cfg_valid = v;
      rst_req   = q;
      cfg_data  = d;
      fire = 1'b0;
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
      fire = !r && p < 0 && ic == 23;
`endif
      mready = !r && !fire && (p < 0 || p == 31);
      #1;
      chk("ready", {31'b0, cfg_ready}, {31'b0, mready});
      acc = mready && (v || q);
      if (r) begin
         p   = -1;
         mfd = 1'b0;
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
         ic    = 0;
         mlast = '0;
`endif
      end else begin
         mfd = (p == 31);
         if (acc) begin
            p = 0;
            if (q) begin
               mword = '0;
               mpat  = RSTW;
            end else begin
               mword = d;
               mpat  = SYNC;
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
               mlast = d;
`endif
            end
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
            ic = 0;
`endif
         end else if (fire) begin
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
            p     = 0;
            mword = mlast;
            mpat  = SYNC;
            ic    = 0;
`endif
         end else if (p >= 0 && p < 31) begin
            p++;
         end else begin
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
            if (p < 0) ic++;
            else ic = 0;
`endif
            p = -1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_s = (p >= 0) ? mword[31-p] : 1'b0;
      exp_t = (p >= 16) ? mpat[31-p] : 1'b0;
      chk("sdata", {31'b0, sdata}, {31'b0, exp_s});
      chk("tms", {31'b0, tms}, {31'b0, exp_t});
      chk("busy", {31'b0, busy}, {31'b0, p >= 0});
      chk("frame_done", {31'b0, frame_done}, {31'b0, mfd});
      rdata = {rdata[30:0], sdata};
      rtms  = {rtms[14:0], tms};
      chk("rx_sync", {31'b0, rtms == SYNC},
          {31'b0, p == 31 && mpat == SYNC});
      if (rtms == SYNC) begin
         nsync++;
         rx_word       = rdata;
         prev_sync_cyc = sync_cyc;
         sync_cyc      = cyc;
         chk("rx_word", rdata, mword);
      end
      if (since_rst >= 32)
         chk("rx_rst", {31'b0, rtms == RSTW},
             {31'b0, p == 31 && mpat == RSTW});
      if (rtms == RSTW) nrst++;
      if (r) since_rst = 0;
      else since_rst++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, $urandom);
   endtask

   task automatic wait_acc(input bit q, input bit v, input logic [31:0] d);
      int n;
      n = 0;
      do begin
         cycle(0, v, q, d);
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("acc_timeout", 32'd0, 32'd1);
   endtask

   int s0;
   int r0;

   initial begin
      reset     = 1'b1;
      cfg_valid = 1'b0;
      rst_req   = 1'b0;
      cfg_data  = '0;
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 32'h1111_1111);

      // single data frame
      s0 = nsync;
      cycle(0, 1, 0, 32'hA5A5_1234);
      idle(40);
      chk("a5_word", rx_word, 32'hA5A5_1234);
`ifndef CFG_JTAG_TX_KEEPALIVE_EN
      chk("a5_strobes", nsync - s0, 32'd1);
`endif

      // back-to-back frames with cfg_valid held
      s0 = nsync;
      wait_acc(0, 1, 32'h0000_0001);
      wait_acc(0, 1, 32'hFFFF_FFFF);
      idle(33);
      chk("b2b_word", rx_word, 32'hFFFF_FFFF);
      chk("b2b_gap", sync_cyc - prev_sync_cyc, 32'd32);
`ifndef CFG_JTAG_TX_KEEPALIVE_EN
      chk("b2b_strobes", nsync - s0, 32'd2);
`endif

      // reset request has priority over data
      r0 = nrst;
      s0 = nsync;
      wait_acc(1, 1, 32'hC0FF_EE11);
      wait_acc(0, 1, 32'hC0FF_EE11);
      idle(33);
      chk("prio_rst", nrst - r0, 32'd1);
      chk("prio_word", rx_word, 32'hC0FF_EE11);

      // reset at bit 20 of a data frame
      s0 = nsync;
      wait_acc(0, 1, 32'h1234_5678);
      for (int i = 0; i < 40 && p != 20; i++) cycle(0, 0, 0, '0);
      chk("at_idx20", p, 32'd20);
      cycle(1, 1, 1, 32'hFFFF_FFFF);
      chk("trunc_none", nsync - s0, 32'd0);
      wait_acc(0, 1, 32'h8765_4321);
      idle(33);
      chk("after_rst_word", rx_word, 32'h8765_4321);

      // long idle: keepalive resends, otherwise line stays quiet
      s0 = nsync;
      idle(130);
`ifdef CFG_JTAG_TX_KEEPALIVE_EN
      chk("ka_strobes", nsync - s0, 32'd2);
      chk("ka_word", rx_word, 32'h8765_4321);
`else
      chk("quiet", nsync - s0, 32'd0);
`endif

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0,
               $urandom);
         if ($urandom_range(0, 99) == 0) idle($urandom_range(1, 60));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
